// File: rtl/cube_sum_ctrl.sv
// Sequencer/collector around the cube engine: issues each non-zero sample with a start
// pulse, waits out the engine's busy code, and accumulates N_SAMPLES cubes into one sum.
module cube_sum_ctrl #(
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       in_x_bi,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [7:0]       cube_x_o,
    output logic             cube_start_o,
    input  logic [1:0]       cube_busy_i,
    input  logic [23:0]      cube_y_i,
    output logic [ACC_W-1:0] sum_bo,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             err_o
);

    localparam int unsigned CntW = $clog2(N_SAMPLES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_SAMPLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StOutput
    } state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [7:0]        x_q, x_d;
    logic              start_q, start_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sum_valid_q, sum_valid_d;
    logic              err_q, err_d;
    logic [ACC_W-1:0]  y_ext;

    assign y_ext = ACC_W'(cube_y_i);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        x_d         = x_q;
        start_d     = 1'b0;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    x_d = in_x_bi;
                    if (in_x_bi == 8'd0) begin
                        // The engine never goes busy for x=0, so count it locally as a zero cube.
                        count_d = count_q + CntW'(1);
                        if (count_q == LastCnt) begin
                            state_d     = StOutput;
                            sum_d       = acc_q;
                            sum_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = StIssue;
                        start_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
                tmo_d   = '0;
            end
            StWaitBusy: begin
                if (cube_busy_i != 2'd0) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitDone: begin
                if (cube_busy_i == 2'd0) begin
                    acc_d   = acc_q + y_ext;
                    count_d = count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_d     = StOutput;
                        sum_d       = acc_q + y_ext;
                        sum_valid_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOutput: begin
                if (sum_ready_i) begin
                    sum_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            x_q         <= '0;
            start_q     <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            x_q         <= x_d;
            start_q     <= start_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            err_q       <= err_d;
        end
    end

    // Start is a register set on entry to ISSUE so the pulse is glitch-free.
    assign cube_start_o = start_q;
    assign cube_x_o     = x_q;
    assign in_ready_o   = (state_q == StIdle) && rst_i;
    assign sum_bo       = sum_q;
    assign sum_valid_o  = sum_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_cube_sum_ctrl.sv
// Bench for cube_sum_ctrl: behavioural cube engine plus batch-sum reference model.
module tb_cube_sum_ctrl;

    localparam int unsigned ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [7:0]       in_x_bi;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [7:0]       cube_x_o;
    logic             cube_start_o;
    logic [1:0]       cube_busy_i;
    logic [23:0]      cube_y_i;
    logic [ACC_W-1:0] sum_bo;
    logic             sum_valid_o;
    logic             sum_ready_i;
    logic             err_o;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int unsigned start_multi = 0;
    int unsigned hold_err = 0;
    int unsigned eng_done_cyc = 0;
    logic        start_prev = 1'b0;
    logic        eng_dead = 1'b0;
    int unsigned eph = 0;
    int unsigned edly = 0;
    int unsigned elen = 0;
    logic [7:0]  ex = 8'd0;
    int unsigned bx [4];

    cube_sum_ctrl #(
        .N_SAMPLES(4),
        .ACC_W    (ACC_W),
        .TIMEOUT  (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_x_bi     (in_x_bi),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .cube_x_o    (cube_x_o),
        .cube_start_o(cube_start_o),
        .cube_busy_i (cube_busy_i),
        .cube_y_i    (cube_y_i),
        .sum_bo      (sum_bo),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic longint cube(input int unsigned x);
        return longint'(x) * longint'(x) * longint'(x);
    endfunction

    // Start-pulse monitor and engine model; engine re-reads x when it finishes.
    always @(negedge clk) begin
        if (cube_start_o) start_cnt++;
        if (cube_start_o && start_prev) start_multi++;
        start_prev = cube_start_o;
        if (!rst_i) begin
            eph = 0;
            cube_busy_i = 2'd0;
        end else begin
            case (eph)
                0: if (cube_start_o && !eng_dead) begin
                    ex   = cube_x_o;
                    edly = $urandom_range(0, 2);
                    eph  = 1;
                end
                1: begin
                    if (cube_x_o !== ex) hold_err++;
                    if (edly == 0) begin
                        cube_busy_i = 2'($urandom_range(1, 3));
                        elen = $urandom_range(1, 4);
                        eph  = 2;
                    end else begin
                        edly--;
                    end
                end
                default: begin
                    if (cube_x_o !== ex) hold_err++;
                    if (elen == 0) begin
                        cube_busy_i  = 2'd0;
                        cube_y_i     = 24'(cube(cube_x_o));
                        eng_done_cyc = cyc;
                        eph = 0;
                    end else begin
                        elen--;
                        cube_busy_i = 2'($urandom_range(1, 3));
                        cube_y_i    = 24'($urandom);
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge; returns on the negedge after the accept edge.
    task automatic send_sample(input int unsigned x, input bit last);
        int unsigned n;
        in_x_bi    = 8'(x);
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {63'd0, in_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_x_bi    = 8'($urandom);
        @(negedge clk);
        chk("operand_reg", {56'd0, cube_x_o}, 64'(x));
        if (x == 0 && !last) chk("zero_one_cycle", {63'd0, in_ready_o}, 64'd1);
    endtask

    task automatic run_batch(input int unsigned ready_delay, input logic exp_err);
        int unsigned s0, h0, nz, n;
        longint      ref_sum;
        s0 = start_cnt;
        h0 = hold_err;
        ref_sum = 0;
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            ref_sum += cube(bx[i]);
            if (bx[i] != 0) nz++;
        end
        for (int i = 0; i < 4; i++) send_sample(bx[i], i == 3);
        n = 0;
        while (!sum_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sum_valid", {63'd0, sum_valid_o}, 64'd1);
        if (bx[3] == 0) chk("zero_last_latency", 64'(n), 64'd0);
        else chk("done_to_valid", 64'(cyc - eng_done_cyc), 64'd1);
        chk("sum", 64'(sum_bo), 64'(ref_sum));
        chk("start_pulses", 64'(start_cnt - s0), 64'(nz));
        chk("err", {63'd0, err_o}, {63'd0, exp_err});
        chk("operand_hold", 64'(hold_err - h0), 64'd0);
        chk("start_width", 64'(start_multi), 64'd0);
        for (int d = 0; d < int'(ready_delay); d++) begin
            @(negedge clk);
            chk("sum_stable", 64'(sum_bo), 64'(ref_sum));
            chk("valid_held", {63'd0, sum_valid_o}, 64'd1);
            chk("backpressure", {63'd0, in_ready_o}, 64'd0);
        end
        sum_ready_i = 1'b1;
        @(negedge clk);
        chk("valid_drop", {63'd0, sum_valid_o}, 64'd0);
        chk("ready_after_out", {63'd0, in_ready_o}, 64'd1);
        sum_ready_i = 1'b0;
    endtask

    initial begin
        int unsigned n;
        rst_i       = 1'b0;
        in_x_bi     = 8'd0;
        in_valid_i  = 1'b0;
        sum_ready_i = 1'b0;
        cube_busy_i = 2'd0;
        cube_y_i    = 24'd0;
        repeat (3) @(negedge clk);
        chk("rst_cube_x", {56'd0, cube_x_o}, 64'd0);
        chk("rst_start", {63'd0, cube_start_o}, 64'd0);
        chk("rst_sum", 64'(sum_bo), 64'd0);
        chk("rst_valid", {63'd0, sum_valid_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);

        bx = '{2, 3, 4, 5};
        run_batch(0, 1'b0);
        bx = '{0, 7, 0, 1};
        run_batch(0, 1'b0);
        bx = '{255, 255, 255, 255};
        run_batch(1, 1'b0);
        bx = '{2, 3, 4, 5};
        run_batch(5, 1'b0);

        // Engine never answers: expect a timeout after 8 cycles in WAIT_BUSY.
        eng_dead = 1'b1;
        send_sample(9, 1'b0);
        n = 0;
        while (!err_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd9);
        chk("timeout_idle", {63'd0, in_ready_o}, 64'd1);
        eng_dead = 1'b0;
        bx = '{1, 1, 1, 1};
        run_batch(0, 1'b1);

        // Reset while the second sample is in WAIT_DONE.
        send_sample(1, 1'b0);
        send_sample(2, 1'b0);
        n = 0;
        #1;
        while (cube_busy_i == 2'd0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("busy_seen", {63'd0, cube_busy_i != 2'd0}, 64'd1);
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_start", {63'd0, cube_start_o}, 64'd0);
        chk("arst_cube_x", {56'd0, cube_x_o}, 64'd0);
        chk("arst_sum", 64'(sum_bo), 64'd0);
        chk("arst_valid", {63'd0, sum_valid_o}, 64'd0);
        chk("arst_err", {63'd0, err_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", {63'd0, in_ready_o}, 64'd1);
        bx = '{1, 2, 3, 4};
        run_batch(1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++)
                bx[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            run_batch($urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cube_sum_ctrl.md
Name: cube_sum_ctrl

Overview:
- Upstream sequencer and downstream collector for the cube engine.
- Accepts a stream of 8-bit samples on a valid/ready handshake and drives each sample into the cube engine with a start pulse.
- Waits for the engine's busy code to complete, captures the 24-bit cube, and accumulates N_SAMPLES cubes.
- Presents the sum on a valid/ready output port.

Parameters:
- N_SAMPLES, 4: cubes per batch (1..256).
- ACC_W, 32: accumulator/sum width; must be >= 24 + clog2(N_SAMPLES).
- TIMEOUT, 8: maximum cycles in WAIT_BUSY before an error is declared.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- in_x_bi  in  8  sample value.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sample accepted when in_valid_i & in_ready_o.
- cube_x_o  out  8  operand to the cube engine x_bi.
- cube_start_o  out  1  one-cycle start pulse to the cube engine.
- cube_busy_i  in  2  cube engine busy code; 0 = idle.
- cube_y_i  in  24  cube engine result.
- sum_bo  out  ACC_W  batch sum of cubes.
- sum_valid_o  out  1  sum_bo valid.
- sum_ready_i  in  1  consumer accepts sum.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; acc=0; count=0.
  - cube_x_o=0, cube_start_o=0, sum_bo=0, sum_valid_o=0, err_o=0.
  - in_ready_o=1 once reset releases.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT.
- IDLE:
  - in_ready_o=1 only in IDLE.
  - On accept, register cube_x_o<=in_x_bi.
  - If in_x_bi==0: the engine never asserts busy for x=0, so do not issue. Count the sample with contribution 0 and stay in IDLE, unless the batch is complete (see count rule).
  - Else go to ISSUE.
- ISSUE: cube_start_o=1 for exactly this one cycle; next state WAIT_BUSY.
- WAIT_BUSY:
  - On cube_busy_i!=0, go to WAIT_DONE.
  - Count cycles spent here; if the count reaches TIMEOUT: err_o<=1 (sticky until reset), acc<=0, count<=0, return to IDLE (batch discarded).
- WAIT_DONE:
  - On cube_busy_i==0, cube_y_i is valid in that same cycle.
  - acc<=acc+zero-extended cube_y_i; count<=count+1.
- Operand hold: cube_x_o must stay unchanged from accept until leaving WAIT_DONE, because the engine re-samples x mid-operation. No new accept is allowed meanwhile.
- Count rule:
  - When count reaches N_SAMPLES (after the x==0 path or WAIT_DONE), the next cycle is OUTPUT.
  - On that transition, sum_bo<=final acc and sum_valid_o<=1.
- OUTPUT:
  - sum_valid_o and sum_bo are held stable until sum_ready_i=1.
  - On the handshake cycle: sum_valid_o<=0, acc<=0, count<=0, go to IDLE.
  - in_ready_o=0 throughout OUTPUT (input back-pressure).
- Width: the accumulator never overflows given the ACC_W rule (max 255^3=16581375 per sample). No saturation logic.
- Latency:
  - From the handshake in WAIT_DONE to sum_valid_o=1 for the last sample: 1 cycle.
  - For a last sample with x=0, sum_valid_o=1 the cycle after its accept.
- Reset mid-operation: everything returns to reset values immediately and cube_start_o drops asynchronously. The engine's own reset is external; the controller re-synchronises by restarting in IDLE.
- Behaviour for cube_busy_i returning to 0 before WAIT_DONE is not defined; the engine does not do this.

Test Plan:
- Batch x=2,3,4,5, N=4, sum_ready_i=1 -> one start pulse per sample; sum_bo=224 with a single-cycle sum_valid_o; err_o=0.
- Batch x=0,7,0,1 -> exactly two start pulses; sum_bo=344; the x=0 samples take 1 cycle each.
- Batch x=255 x4 -> sum_bo=66325500; cube_x_o is stable from accept through WAIT_DONE for every sample.
- Hold sum_ready_i=0 for 5 cycles after sum_valid_o -> sum_bo stays 224 and in_ready_o=0. Then ready=1 -> valid drops next cycle and in_ready_o=1.
- Tie cube_busy_i=0 and send x=9 -> err_o=1 after TIMEOUT=8 cycles in WAIT_BUSY. The batch is discarded; the next batch 1,1,1,1 gives sum_bo=4 with err_o still 1.
- Assert rst_i=0 during WAIT_DONE of the second sample -> all outputs at reset values. A fresh batch 1,2,3,4 then gives sum_bo=100.
